// File: rtl/bcd_seg_pkg.sv
// Shared constants and types for the multiplexed 3-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_seg_pkg;

    localparam int DIGITS = 3;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    function automatic logic nib_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles render as a dash and raise the invalid flag.
module bcd_to_seg
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o,
    output logic       invalid_o
);

    always_comb begin
        seg_o     = SEG_DASH;
        invalid_o = 1'b0;
        unique case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// 3-digit multiplexed seven-segment driver: snapshots a BCD value on load and
// scans digits with a dwell period and an all-off gap between digits.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 100
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        err
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [1:0]       DIG_LAST   = 2'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [11:0]      snap_q;
    logic [11:0]      disp_q, disp_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             err_q, err_d;

    logic             phase_done;
    logic [3:0]       disp_nib [DIGITS];
    logic [DIGITS-1:0] nib_bad;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic             dec_invalid;
    logic             lz_blank;

    assign phase_done = (state_q == S_BLANK) ? (cnt_q == BLANK_LAST)
                                             : (cnt_q == SHOW_LAST);

    // State register, plus the snapshot and display copies.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            dig_q   <= '0;
            snap_q  <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= 3'b111;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
            if (load) begin
                snap_q <= bcd_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        dig_d   = dig_q;
        disp_d  = disp_q;
        if (phase_done) begin
            cnt_d = '0;
            if (state_q == S_BLANK) begin
                state_d = S_SHOW;
                disp_d  = snap_q;
            end else begin
                state_d = S_BLANK;
                dig_d   = (dig_q == DIG_LAST) ? 2'd0 : dig_q + 2'd1;
            end
        end
    end

    // Decode path looks at the value disp is about to hold, so seg and err
    // change on the same edge that disp is refreshed.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = disp_d[4*gi +: 4];
            assign nib_bad[gi]  = nib_invalid(disp_nib[gi]);
        end
    endgenerate

    always_comb begin
        cur_nib = disp_nib[0];
        case (dig_q)
            2'd1:    cur_nib = disp_nib[1];
            2'd2:    cur_nib = disp_nib[2];
            default: cur_nib = disp_nib[0];
        endcase
    end

    bcd_to_seg u_dec (
        .nib_i     (cur_nib),
        .seg_o     (dec_seg),
        .invalid_o (dec_invalid)
    );

    assign lz_blank = blank_lz && !dec_invalid &&
                      (((dig_q == 2'd2) && (disp_nib[2] == 4'd0)) ||
                       ((dig_q == 2'd1) && (disp_nib[2] == 4'd0) && (disp_nib[1] == 4'd0)));

    always_comb begin
        seg_d = seg_q;
        an_d  = an_q;
        err_d = err_q;
        if (phase_done) begin
            if (state_q == S_BLANK) begin
                an_d  = ~(3'b001 << dig_q);
                seg_d = lz_blank ? SEG_OFF : dec_seg;
                err_d = |nib_bad;
            end else begin
                an_d  = 3'b111;
                seg_d = SEG_OFF;
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a timeline model predicts every digit
// presentation, and a negedge monitor compares what the display shows.
module tb_bcd_seg_scan;

    localparam int SD = 4;
    localparam int BC = 2;
    localparam int P  = SD + BC;

    logic        clk_100 = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        err;

    always #5 clk_100 = ~clk_100;

    bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk_100  (clk_100),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         e;
        logic [2:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    int          e_cnt = 0;
    logic [11:0] m_snap = 12'h000;
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Expected presentation of digit d for a held value v.
    function automatic exp_t predict(input int e, input logic [11:0] v,
                                     input logic lz, input int d);
        exp_t r;
        int h, t, u, n;
        h = int'(v[11:8]);
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        n = (d == 0) ? u : (d == 1) ? t : h;
        r.e   = e;
        r.an  = 3'b111;
        r.an[d] = 1'b0;
        r.err = (h > 9) || (t > 9) || (u > 9);
        if (n > 9)
            r.seg = 7'h3F;
        else if (lz && (((d == 2) && (h == 0)) || ((d == 1) && (h == 0) && (t == 0))))
            r.seg = 7'h7F;
        else
            r.seg = seg_tab[n];
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] rnib();
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Timeline model: edges since reset release decide when each digit lights.
    always @(posedge clk_100) begin
        if (rst) begin
            e_cnt = 0;
            m_snap = 12'h000;
            exp_q.delete();
        end else begin
            e_cnt++;
            if (e_cnt >= BC && ((e_cnt - BC) % P) == 0) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL missed_show edge=%0d pending=%0d required pending=0",
                             e_cnt, exp_q.size());
                end
                exp_q.push_back(predict(e_cnt, m_snap, blank_lz, ((e_cnt - BC) / P) % 3));
            end
            if (load) m_snap = bcd_in;
        end
    end

    logic [2:0] prev_an = 3'b111;
    logic [6:0] held_seg = 7'h7F;
    int         dwell = 0;

    always @(negedge clk_100) begin
        exp_t x;
        if (rst) begin
            prev_an = 3'b111;
            dwell = 0;
        end else begin
            if (an != 3'b111) begin
                if (prev_an == 3'b111) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_show edge=%0d an=%b seg=%h required no show",
                                 e_cnt, an, seg);
                    end else begin
                        x = exp_q.pop_front();
                        $display("show edge=%0d an=%b seg=%h err=%b", e_cnt, an, seg, err);
                        if (x.e != e_cnt || x.an != an || x.seg != seg || x.err != err) begin
                            failures++;
                            $display("FAIL show_entry edge=%0d an=%b seg=%h err=%b required edge=%0d an=%b seg=%h err=%b",
                                     e_cnt, an, seg, err, x.e, x.an, x.seg, x.err);
                        end
                    end
                    held_seg = seg;
                    dwell = 1;
                end else begin
                    dwell++;
                    checks++;
                    if (an != prev_an || seg != held_seg) begin
                        failures++;
                        $display("FAIL dwell_stable edge=%0d an=%b seg=%h required an=%b seg=%h",
                                 e_cnt, an, seg, prev_an, held_seg);
                    end
                end
            end else begin
                checks++;
                if (seg != 7'h7F) begin
                    failures++;
                    $display("FAIL blank_seg edge=%0d seg=%h required 7f", e_cnt, seg);
                end
                if (prev_an != 3'b111) begin
                    checks++;
                    if (dwell != SD) begin
                        failures++;
                        $display("FAIL dwell_len edge=%0d got=%0d required %0d", e_cnt, dwell, SD);
                    end
                end
            end
            prev_an = an;
        end
    end

    task automatic do_load(input logic [11:0] v);
        @(negedge clk_100);
        bcd_in = v;
        load = 1'b1;
        @(negedge clk_100);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic wait_lit(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk_100);
            if (an != 3'b111) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout an=%b required a lit digit", tag, an);
        end
    endtask

    task automatic check_dark(input string tag);
        checks++;
        if (an != 3'b111 || seg != 7'h7F || err != 1'b0) begin
            failures++;
            $display("FAIL %s an=%b seg=%h err=%b required an=111 seg=7f err=0",
                     tag, an, seg, err);
        end
    endtask

    initial begin
        int v;
        #1 rst = 1'b1;
        #1 check_dark("reset_state");
        repeat (2) @(posedge clk_100);
        @(negedge clk_100);
        rst = 1'b0;

        // Scan order and plain decode
        blank_lz = 1'b0;
        do_load(12'h123);
        run(3 * P * 2);

        // Leading-zero blanking on and off
        blank_lz = 1'b1;
        do_load(12'h007);
        run(3 * P * 2);
        blank_lz = 1'b0;
        run(3 * P * 2);

        // Invalid nibble then recovery
        do_load(12'h1A5);
        run(3 * P * 2);
        do_load(12'h105);
        run(3 * P * 2);

        // Load mid-dwell
        wait_lit("middwell");
        run(1);
        do_load(12'h456);
        run(3 * P * 2);

        // Load coincident with the blank-to-show edge
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk_100);
            if (((e_cnt + 1 - BC) % P) == 0) break;
        end
        bcd_in = 12'h789;
        load = 1'b1;
        @(negedge clk_100);
        load = 1'b0;
        run(3 * P * 2);

        // Asynchronous reset while a digit is lit
        do_load(12'h888);
        wait_lit("reset_show");
        #2 rst = 1'b1;
        #1 check_dark("reset_mid_show");
        @(posedge clk_100);
        #1 check_dark("reset_held");
        @(negedge clk_100);
        rst = 1'b0;
        run(3 * P * 2);

        // Randomized loads, held loads, invalid nibbles and blanking toggles
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_100);
            bcd_in = {($urandom_range(0, 1) == 0) ? 4'd0 : rnib(),
                      ($urandom_range(0, 2) == 0) ? 4'd0 : rnib(),
                      rnib()};
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if (load) load = ($urandom_range(0, 2) != 0);
            else      load = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk_100);
        load = 1'b0;
        run(3 * P);

        // BCD counter drive through 999 -> 000 with load on carry-out
        blank_lz = 1'b1;
        v = 985;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_100);
            bcd_in = to_bcd(v);
            load = (v == 999);
            v = (v + 1) % 1000;
        end
        @(negedge clk_100);
        load = 1'b0;
        run(3 * P * 2);

        @(negedge clk_100);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed 3-digit seven-segment display driver that consumes the 12-bit, 3-digit BCD count produced by the BCD counter (`q_t`). It sits between the counter and the board's common-anode display. It captures a BCD snapshot on a load strobe and scans the digits one at a time, with a programmable dwell time and an anti-ghosting blank gap between digits. It also provides optional leading-zero blanking and flags invalid BCD nibbles.

## Interface
Parameters:
- `SCAN_DIV`, default 100000, is the number of cycles each digit is lit (1 ms at 100 MHz). Must be ≥ 2.
- `BLANK_CYC`, default 100, is the number of cycles all anodes are off between digits. Must be ≥ 1.

Ports:
- `clk_100` is an input, 1 bit: the system clock (100 MHz). It is the only clock.
- `rst` is an input, 1 bit: asynchronous, active-high reset.
- `bcd_in` is an input, 12 bits: 3-digit BCD value. [3:0] is units, [7:4] is tens, [11:8] is hundreds.
- `load` is an input, 1 bit: when high on a rising edge, `bcd_in` is captured into the snapshot register.
- `blank_lz` is an input, 1 bit: when 1, leading-zero blanking is enabled.
- `seg` is an output, 7 bits: {g,f,e,d,c,b,a}, active-low.
- `an` is an output, 3 bits: digit enables, active-low. an[0] is units, an[2] is hundreds.
- `err` is an output, 1 bit: 1 while the displayed value contains any nibble greater than 9.

## Operation
- Registers:
  - `snap` (12 bits) loads from `bcd_in` on `load`.
  - `disp` (12 bits) copies `snap` on every BLANK→SHOW transition, so a value never changes mid-digit.
- FSM has two states: S_BLANK and S_SHOW. It uses a digit index `dig` (0..2) and a cycle counter.
  - S_BLANK: hold for BLANK_CYC cycles, then go to S_SHOW.
  - S_SHOW: hold for SCAN_DIV cycles, then go to S_BLANK and advance `dig` (2 wraps to 0).
- Outputs are registered and update on the same edge as the state change.
  - S_BLANK: an=3'b111, seg=7'h7F.
  - S_SHOW: an has only bit `dig` low; seg is the decode of `disp` digit `dig`.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibble A–F shows a dash (7'h3F).
  - A blanked digit shows 7'h7F with its anode still driven low.
- Leading-zero blanking (`blank_lz`=1):
  - Hundreds is blanked if it is 0.
  - Tens is blanked if hundreds and tens are both 0.
  - Units is never blanked.
  - Invalid nibbles are never blanked.
- `err` is registered from `disp` and updates on the same edge as `disp`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - an=3'b111, seg=7'h7F, err=0.
  - snap=0, disp=0, dig=0.
  - State S_BLANK, counter 0.
- After reset release:
  - S_BLANK lasts BLANK_CYC cycles.
  - Digit 0 is then lit for SCAN_DIV cycles.
  - One digit period is BLANK_CYC+SCAN_DIV cycles; one frame is 3×(BLANK_CYC+SCAN_DIV).
- Load latency:
  - `snap` updates 1 edge after `load`.
  - The new value reaches `seg` at the next S_SHOW entry.
- Load on the same edge as BLANK→SHOW: `disp` takes the old `snap`, and the new value is shown from the next digit onward.
- `load` held high: `snap` tracks `bcd_in` every cycle.
- `blank_lz` is sampled combinationally into the registered `seg` at S_SHOW entry and held through the dwell.
- Reset mid-SHOW: outputs go dark immediately. The scan restarts at digit 0 after BLANK_CYC.

## Structure
- Package `bcd_seg_pkg` holds:
  - the `DIGITS`=3 constant,
  - the state enum {S_BLANK, S_SHOW},
  - the 11 segment pattern constants (0–9 and dash) plus SEG_OFF=7'h7F.
- Counter width is $clog2 of max(SCAN_DIV, BLANK_CYC).
- Sub-module `bcd_to_seg` is a combinational nibble→pattern decoder with an invalid flag. It is instantiated once, on the muxed digit.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYC=2.
- **Reset:** assert `rst` mid-SHOW. Required: an=111, seg=7F, err=0 in the same cycle. After release, 2 blank cycles, then an=110.
- **Scan order:** load 12'h123, blank_lz=0. Required: an sequence 110/101/011 with seg 30/24/79, each held 4 cycles and separated by 2 cycles of an=111, period 18.
- **Leading zeros:** load 12'h007, blank_lz=1. Required: units seg=78, tens and hundreds seg=7F. With blank_lz=0, tens and hundreds show 40.
- **Invalid nibble:** load 12'h1A5. Required: tens seg=3F and err=1. Then load 12'h105; err returns to 0 at the next S_SHOW entry.
- **Tear-free load:** change `bcd_in` and pulse `load` mid-dwell. Required: seg stays stable until the next blank, and the new value appears at the following S_SHOW. A load coincident with the BLANK→SHOW edge is shown one digit later.
- **Counter drive:** connect the BCD counter's q_t with load=cout_t and run a count through 999→000. Required: the display matches each captured value and `dig` wraps 2→0 without a gap.
